// File: rtl/fifo_sync_param_pkg.sv
// rtl/fifo_sync_param_pkg.sv - shared sizing helpers and read-mode type for the parametrised FIFO
package fifo_pkg;

    typedef enum logic {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } rd_mode_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

    // Explicit wrap so non-power-of-two depths index only valid entries.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// rtl/fifo_sync_param_if.sv - producer/consumer signal bundle for fifo_sync_param
interface fifo_sync_param_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CNT_W = cnt_w(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             err_clr;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param_mem.sv
// rtl/fifo_sync_param_mem.sv - FIFO storage array, one write port and one asynchronous read port
module fifo_mem
    import fifo_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [PTR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [PTR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - synchronous FIFO with configurable depth, FWFT mode, threshold flags and sticky errors
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = 3,
    parameter int AE_THRESH = 1
) (
    input logic               clk,
    input logic               rst,
    fifo_sync_param_if.slave  bus
);
    localparam int       CNT_W = cnt_w(DEPTH);
    localparam int       PTR_W = ptr_w(DEPTH);
    localparam rd_mode_e MODE  = (FWFT != 0) ? MODE_FWFT : MODE_STD;

    if (DEPTH < 2) begin : g_chk_depth
        $error("fifo_sync_param: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_chk_af
        $error("fifo_sync_param: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_chk_ae
        $error("fifo_sync_param: AE_THRESH out of range 0..DEPTH-1");
    end

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [WIDTH-1:0] w_mem_rd;

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    // A write into a full FIFO is still accepted when a read frees a slot the same cycle.
    assign w_rd_acc = bus.rd_en & ~w_empty;
    assign w_wr_acc = bus.wr_en & (~w_full | w_rd_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= PTR_W'(ptr_inc(32'(r_wr_ptr), 32'(DEPTH)));
            end
            if (w_rd_acc) begin
                r_rd_ptr <= PTR_W'(ptr_inc(32'(r_rd_ptr), 32'(DEPTH)));
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (bus.wr_en && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_overflow <= 1'b0;
            end
            if (bus.rd_en && !w_rd_acc) begin
                r_underflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_mem_rd)
    );

    if (MODE == MODE_STD) begin : g_std
        logic [WIDTH-1:0] r_rd_data;
        logic             r_rd_valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_rd_acc;
                if (w_rd_acc) begin
                    r_rd_data <= w_mem_rd;
                end
            end
        end

        assign bus.rd_data  = r_rd_data;
        assign bus.rd_valid = r_rd_valid;
    end else begin : g_fwft
        assign bus.rd_data  = w_mem_rd;
        assign bus.rd_valid = ~w_empty;
    end

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= CNT_W'(AF_THRESH));
    assign bus.almost_empty = (r_count <= CNT_W'(AE_THRESH));
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - self-checking bench: spec vector table plus queue scoreboard over three FIFO configurations
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr, rd, clr;
    logic [7:0] wd;

    always #5 clk = ~clk;

    fifo_sync_param_if #(.WIDTH(8), .DEPTH(4)) if0 ();
    fifo_sync_param_if #(.WIDTH(8), .DEPTH(4)) if1 ();
    fifo_sync_param_if #(.WIDTH(8), .DEPTH(5)) if2 ();

    assign if0.wr_en = wr;  assign if0.wr_data = wd;  assign if0.rd_en = rd;  assign if0.err_clr = clr;
    assign if1.wr_en = wr;  assign if1.wr_data = wd;  assign if1.rd_en = rd;  assign if1.err_clr = clr;
    assign if2.wr_en = wr;  assign if2.wr_data = wd;  assign if2.rd_en = rd;  assign if2.err_clr = clr;

    fifo_sync_param #(.WIDTH(8), .DEPTH(4), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1))
        dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    fifo_sync_param #(.WIDTH(8), .DEPTH(4), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1))
        dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    fifo_sync_param #(.WIDTH(8), .DEPTH(5), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1))
        dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    int         sel;
    logic [7:0] o_data;
    logic [2:0] o_cnt;
    logic       o_rv, o_full, o_empty, o_af, o_ae, o_ovf, o_uf;

    assign o_data  = (sel == 2) ? if2.rd_data      : (sel == 1) ? if1.rd_data      : if0.rd_data;
    assign o_cnt   = (sel == 2) ? if2.count        : (sel == 1) ? if1.count        : if0.count;
    assign o_rv    = (sel == 2) ? if2.rd_valid     : (sel == 1) ? if1.rd_valid     : if0.rd_valid;
    assign o_full  = (sel == 2) ? if2.full         : (sel == 1) ? if1.full         : if0.full;
    assign o_empty = (sel == 2) ? if2.empty        : (sel == 1) ? if1.empty        : if0.empty;
    assign o_af    = (sel == 2) ? if2.almost_full  : (sel == 1) ? if1.almost_full  : if0.almost_full;
    assign o_ae    = (sel == 2) ? if2.almost_empty : (sel == 1) ? if1.almost_empty : if0.almost_empty;
    assign o_ovf   = (sel == 2) ? if2.overflow     : (sel == 1) ? if1.overflow     : if0.overflow;
    assign o_uf    = (sel == 2) ? if2.underflow    : (sel == 1) ? if1.underflow    : if0.underflow;

    // Reference model: stored words, pending registered reads, sticky flags.
    logic [7:0] mq[$];
    logic [7:0] sb[$];
    int         m_depth;
    bit         m_fwft, m_ovf, m_uf, m_rv;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic       clr;
        int         cnt;
        logic       full, empty, af, ovf, uf, rv;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic w, logic [7:0] d, logic r, logic c, int n,
                               logic f, logic e, logic a, logic o, logic u, logic rv,
                               logic [7:0] dat);
        vec_t x;
        x.wr = w; x.wd = d; x.rd = r; x.clr = c; x.cnt = n;
        x.full = f; x.empty = e; x.af = a; x.ovf = o; x.uf = u; x.rv = rv; x.dat = dat;
        return x;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(string tag);
        int         n;
        logic [7:0] e;
        n = mq.size();
        check({tag, ".count"}, 32'(o_cnt), n);
        check({tag, ".full"},  32'(o_full),  32'(n == m_depth));
        check({tag, ".empty"}, 32'(o_empty), 32'(n == 0));
        check({tag, ".af"},    32'(o_af),    32'(n >= 3));
        check({tag, ".ae"},    32'(o_ae),    32'(n <= 1));
        check({tag, ".ovf"},   32'(o_ovf),   32'(m_ovf));
        check({tag, ".uf"},    32'(o_uf),    32'(m_uf));
        if (m_fwft) begin
            check({tag, ".rv"}, 32'(o_rv), 32'(n != 0));
            if (n != 0) check({tag, ".fwft_data"}, 32'(o_data), 32'(mq[0]));
        end else begin
            check({tag, ".rv"}, 32'(o_rv), 32'(m_rv));
            if (o_rv === 1'b1) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL %s.sb: got rd_valid=1 with data %0h expected no pending read", tag, o_data);
                end else begin
                    e = sb.pop_front();
                    check({tag, ".rd_data"}, 32'(o_data), 32'(e));
                end
            end
        end
    endtask

    task automatic step(logic w, logic [7:0] d, logic r, logic c, string tag);
        bit         racc, wacc;
        logic [7:0] head;
        wr = w; wd = d; rd = r; clr = c;
        racc = r && (mq.size() != 0);
        wacc = w && ((mq.size() != m_depth) || racc);
        if (racc) begin
            head = mq.pop_front();
            if (!m_fwft) sb.push_back(head);
        end
        if (wacc) mq.push_back(d);
        m_ovf = (w && !wacc) ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_uf  = (r && !racc) ? 1'b1 : (c ? 1'b0 : m_uf);
        m_rv  = racc;
        @(posedge clk); #1;
        wr = 0; rd = 0; clr = 0;
        check_model(tag);
    endtask

    task automatic model_clear();
        mq.delete(); sb.delete();
        m_ovf = 0; m_uf = 0; m_rv = 0;
    endtask

    task automatic do_reset(int s);
        sel = s; m_depth = (s == 2) ? 5 : 4; m_fwft = (s == 1);
        rst = 1; wr = 0; rd = 0; clr = 0; wd = 8'h00;
        @(posedge clk); #1;
        rst = 0;
        model_clear();
        check_model($sformatf("reset%0d", s));
    endtask

    initial begin
        rst = 1; wr = 0; rd = 0; clr = 0; wd = 0; sel = 0;

        // wr wd rd clr | cnt full empty af ovf uf rv dat
        tbl.push_back(v(1, 8'h11, 0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(v(1, 8'h22, 0, 0, 2, 0, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(v(1, 8'h33, 0, 0, 3, 0, 0, 1, 0, 0, 0, 8'h00));
        tbl.push_back(v(1, 8'h44, 0, 0, 4, 1, 0, 1, 0, 0, 0, 8'h00));
        tbl.push_back(v(1, 8'h55, 0, 0, 4, 1, 0, 1, 1, 0, 0, 8'h00));
        tbl.push_back(v(0, 8'h00, 1, 0, 3, 0, 0, 1, 1, 0, 1, 8'h11));
        tbl.push_back(v(0, 8'h00, 1, 1, 2, 0, 0, 0, 0, 0, 1, 8'h22));
        tbl.push_back(v(0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 0, 1, 8'h33));
        tbl.push_back(v(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0, 1, 8'h44));
        tbl.push_back(v(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 1, 0, 8'h00));
        tbl.push_back(v(0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00));
        tbl.push_back(v(1, 8'hA0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(v(1, 8'hA1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(v(1, 8'hA2, 0, 0, 3, 0, 0, 1, 0, 0, 0, 8'h00));
        tbl.push_back(v(1, 8'hA3, 0, 0, 4, 1, 0, 1, 0, 0, 0, 8'h00));
        tbl.push_back(v(1, 8'hB0, 1, 0, 4, 1, 0, 1, 0, 0, 1, 8'hA0));
        tbl.push_back(v(0, 8'h00, 1, 0, 3, 0, 0, 1, 0, 0, 1, 8'hA1));
        tbl.push_back(v(0, 8'h00, 1, 0, 2, 0, 0, 0, 0, 0, 1, 8'hA2));
        tbl.push_back(v(0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 0, 1, 8'hA3));
        tbl.push_back(v(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0, 1, 8'hB0));
        tbl.push_back(v(1, 8'hC0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 8'h00));
        tbl.push_back(v(0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(v(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0, 1, 8'hC0));

        // Standard read mode, DEPTH=4: fill, drain, pass-through at full, write+read at empty.
        do_reset(0);
        foreach (tbl[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].clr, t);
            check({t, ".tbl_count"}, 32'(o_cnt),   32'(tbl[i].cnt));
            check({t, ".tbl_full"},  32'(o_full),  32'(tbl[i].full));
            check({t, ".tbl_empty"}, 32'(o_empty), 32'(tbl[i].empty));
            check({t, ".tbl_af"},    32'(o_af),    32'(tbl[i].af));
            check({t, ".tbl_ovf"},   32'(o_ovf),   32'(tbl[i].ovf));
            check({t, ".tbl_uf"},    32'(o_uf),    32'(tbl[i].uf));
            check({t, ".tbl_rv"},    32'(o_rv),    32'(tbl[i].rv));
            if (tbl[i].rv) check({t, ".tbl_data"}, 32'(o_data), 32'(tbl[i].dat));
        end
        check("fwft0.sb_drained", 32'(sb.size()), 0);

        // First-word-fall-through: word visible without rd_en, pop empties next cycle.
        do_reset(1);
        step(1, 8'hA5, 0, 0, "fwft.wr");
        check("fwft.rv_after_wr",   32'(o_rv),   1);
        check("fwft.data_after_wr", 32'(o_data), 32'h0A5);
        step(0, 8'h00, 0, 0, "fwft.hold");
        check("fwft.data_held", 32'(o_data), 32'h0A5);
        step(0, 8'h00, 1, 0, "fwft.pop");
        check("fwft.empty_after_pop", 32'(o_empty), 1);
        check("fwft.rv_after_pop",    32'(o_rv),    0);

        // DEPTH=5: both pointers wrap twice while data order is preserved.
        do_reset(2);
        for (int i = 0; i < 12; i++) begin
            step(1, 8'h30 + 8'(i), (i >= 2) ? 1'b1 : 1'b0, 0, $sformatf("wrap%0d", i));
        end
        step(0, 8'h00, 1, 0, "wrap.drain0");
        step(0, 8'h00, 1, 0, "wrap.drain1");
        check("wrap.sb_drained", 32'(sb.size()), 0);
        check("wrap.empty_end",  32'(o_empty),   1);

        // Reset mid-stream, with a write presented alongside to confirm reset priority.
        step(1, 8'h71, 0, 0, "mid.w0");
        step(1, 8'h72, 0, 0, "mid.w1");
        step(1, 8'h73, 1, 0, "mid.w2r");
        rst = 1; wr = 1; wd = 8'h99;
        @(posedge clk); #1;
        rst = 0; wr = 0;
        model_clear();
        check("mid.count",    32'(o_cnt),   0);
        check("mid.empty",    32'(o_empty), 1);
        check("mid.rd_valid", 32'(o_rv),    0);
        check_model("mid.post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
